mdu_ex: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, directly upstream of the memory stage.
- Executes mult/multu/div/divu and mthi/mtlo, and holds the HI/LO architectural registers.
- mfhi/mflo values are taken from the HI/LO outputs into the EX result mux, and from there travel down as the ALU-out value to the memory stage.
- The hazard unit stalls D/E while busy is high, or while start is high with a new md op in E.

---
 rtl/mdu_ex.sv | 130 +++++++++++++
 tb/tb_mdu_ex.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_ex.sv
// rtl/mdu_ex.sv - EX-stage multiply/divide unit holding the HI/LO registers
// Optional madd/maddu accumulate support is enabled by defining MDU_MADD_EN.
module mdu_ex #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [63:0]   res_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  // busy comes purely from the counter so start never reaches it combinationally
  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Result of the latched operation, written to HI/LO on the final RUN edge
  always_comb begin
    res_d = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  res_d = prod_s;
      OP_MULTU: res_d = prod_u;
      OP_DIV: begin
        if (b_q == 32'h0) begin
          res_d = {a_q, 32'hFFFF_FFFF};
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          // Quotient overflows; defined as the dividend with zero remainder
          res_d = {32'h0, 32'h8000_0000};
        end else begin
          res_d = {32'($signed(a_q) % $signed(b_q)), 32'($signed(a_q) / $signed(b_q))};
        end
      end
      OP_DIVU: begin
        if (b_q == 32'h0) begin
          res_d = {a_q, 32'hFFFF_FFFF};
        end else begin
          res_d = {a_q % b_q, a_q / b_q};
        end
      end
`ifdef MDU_MADD_EN
      // Accumulates into HI/LO as they stand at completion
      OP_MADD:  res_d = {hi_q, lo_q} + prod_s;
      OP_MADDU: res_d = {hi_q, lo_q} + prod_u;
`endif
      default:  res_d = {hi_q, lo_q};
    endcase
  end

  // Accept, countdown and HI/LO update; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
    end else if (busy) begin
      cnt_q <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_q <= res_d[63:32];
        lo_q <= res_d[31:0];
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          op_q  <= op;
          a_q   <= A;
          b_q   <= B;
          cnt_q <= MULT_LD;
        end
        OP_DIV, OP_DIVU: begin
          op_q  <= op;
          a_q   <= A;
          b_q   <= B;
          cnt_q <= DIV_LD;
        end
        OP_MTHI: hi_q <= A;
        OP_MTLO: lo_q <= A;
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: begin
          op_q  <= op;
          a_q   <= A;
          b_q   <= B;
          cnt_q <= MULT_LD;
        end
`else
        OP_MADD, OP_MADDU: ;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ex.sv
// tb/tb_mdu_ex.sv - directed self-checking bench for mdu_ex
module tb_mdu_ex;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors;
  int miscompares;

  mdu_ex #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse, then count cycles busy stays high (bounded)
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    A     = 32'h5A5A_5A5A;
    B     = 32'hA5A5_A5A5;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  int n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'h0;
    B     = 32'h0;
    tick();
    tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    reset = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd2, n);
    chk("divu_cycles", n, 32'd10);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    run_op(3'd2, 32'h1234_5678, 32'd0, n);
    chk("div0_lo", LO, 32'hFFFF_FFFF);
    chk("div0_hi", HI, 32'h1234_5678);

    run_op(3'd3, 32'h1234_5678, 32'd0, n);
    chk("divu0_lo", LO, 32'hFFFF_FFFF);
    chk("divu0_hi", HI, 32'h1234_5678);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0);

    // mult 4x5, then an illegal mthi while busy must be ignored
    start = 1'b1; op = 3'd0; A = 32'd4; B = 32'd5;
    tick();
    start = 1'b0;
    chk("ign_busy_c1", {31'b0, busy}, 32'd1);
    tick();
    start = 1'b1; op = 3'd4; A = 32'h0000_DEAD;
    tick();
    start = 1'b0;
    chk("ign_hi_mid", HI, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("ign_cycles_left", n, 32'd3);
    chk("ign_lo", LO, 32'd20);
    chk("ign_hi", HI, 32'd0);

    start = 1'b1; op = 3'd4; A = 32'h0000_DEAD;
    tick();
    start = 1'b0;
    chk("mthi_hi", HI, 32'h0000_DEAD);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_lo", LO, 32'd20);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("rst_pre_busy", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("rst_after_busy", {31'b0, busy}, 32'd0);
    chk("rst_after_hi", HI, 32'h0);
    chk("rst_after_lo", LO, 32'h0);

    // mtlo 10 then madd 3x4
    start = 1'b1; op = 3'd5; A = 32'd10;
    tick();
    start = 1'b0;
    chk("mtlo_lo", LO, 32'd10);
    run_op(3'd6, 32'd3, 32'd4, n);
`ifdef MDU_MADD_EN
    chk("madd_cycles", n, 32'd5);
    chk("madd_lo", LO, 32'd22);
`else
    chk("madd_cycles", n, 32'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("madd_busy", {31'b0, busy}, 32'd0);
    chk("madd_lo", LO, 32'd10);
`endif
    chk("madd_hi", HI, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
